// File: rtl/aes_stream_loader_pkg.sv
// Shared types and constants for the AES stream loader: block/word types,
// block geometry and the loader state encoding.
package aes_stream_loader_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef logic [127:0]      block_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } loader_state_t;

    // True when a 2-bit word index points at the final word of a block.
    function automatic logic is_last_word(input logic [1:0] cnt);
        return (cnt == 2'(WORDS_PER_BLOCK - 1));
    endfunction

endpackage

// File: rtl/aes_stream_loader_word_packer.sv
// 32->128 bit packing shift register. Each shift pushes one word in at the
// low end, so the first word of a block ends up in bits [127:96]. The full
// flag rises with the 4th word and falls again with the first word of the
// next block; done_o marks the shift that completes a block.
module aes_stream_loader_word_packer
    import aes_stream_loader_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   shift_i,
    input  logic   clr_i,
    input  word_t  word_i,
    output block_t data_o,
    output logic   full_o,
    output logic   done_o
);

    block_t     data_q, data_d;
    logic [1:0] cnt_q,  cnt_d;
    logic       full_q, full_d;

    // Next-state logic for the shift register, word count and full flag.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            cnt_d  = 2'd0;
            full_d = 1'b0;
        end else if (shift_i) begin
            data_d = {data_q[95:0], word_i};
            if (is_last_word(cnt_q)) begin
                cnt_d  = 2'd0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    full_d = 1'b0;
                end else begin
                    full_d = full_q;
                end
            end
        end else begin
            data_d = data_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= 128'h0;
            cnt_q  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;
    assign done_o = shift_i && is_last_word(cnt_q);

endmodule

// File: rtl/aes_stream_loader.sv
// Stream front end for the AES core: packs key and plaintext words into
// 128-bit blocks, launches the core, waits its fixed latency, then streams
// the captured cipher text back out as four 32-bit words.
module aes_stream_loader
    import aes_stream_loader_pkg::*;
#(
    parameter int CORE_LATENCY = 40
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_key,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
    output logic         err_drop,
    output logic [127:0] key_in,
    output logic [127:0] plain_text,
    output logic         restart,
    output logic         start,
    input  logic [127:0] cipher_text
);

    localparam logic [7:0] LAT_END = 8'(CORE_LATENCY);

    loader_state_t state_q, state_d;
    logic [7:0]    lat_q, lat_d;
    block_t        out_buf_q, out_buf_d;
    logic [1:0]    word_cnt_q, word_cnt_d;

    logic s_ready_q, s_ready_d;
    logic m_valid_q, m_valid_d;
    logic m_last_q,  m_last_d;
    logic start_q,   start_d;
    logic restart_q;
    logic err_drop_q;

    logic accept_s, key_shift_s, pt_shift_s, drop_s, pt_clr_s, hs_s;
    logic key_loaded_s, key_done_s, pt_full_s, pt_done_unused_s;

    assign accept_s    = s_valid && s_ready_q;
    assign key_shift_s = accept_s && s_key;
    assign pt_shift_s  = accept_s && !s_key && !pt_full_s;
    assign drop_s      = accept_s && !s_key && pt_full_s;
    assign pt_clr_s    = (state_q == START);
    assign hs_s        = m_valid_q && m_ready;

    aes_stream_loader_word_packer u_key_packer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .shift_i (key_shift_s),
        .clr_i   (1'b0),
        .word_i  (s_data),
        .data_o  (key_in),
        .full_o  (key_loaded_s),
        .done_o  (key_done_s)
    );

    aes_stream_loader_word_packer u_pt_packer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .shift_i (pt_shift_s),
        .clr_i   (pt_clr_s),
        .word_i  (s_data),
        .data_o  (plain_text),
        .full_o  (pt_full_s),
        .done_o  (pt_done_unused_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; launch waits out the restart pulse so the core
    // never sees restart and start together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (pt_full_s && key_loaded_s && !restart_q) begin
                    state_d = START;
                end else begin
                    state_d = LOAD;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (lat_q == LAT_END) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (hs_s && m_last_q) begin
                    state_d = LOAD;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Latency counter, cipher capture and output word shifting.
    always_comb begin
        lat_d      = lat_q;
        out_buf_d  = out_buf_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            START: lat_d = 8'd1;
            WAIT: begin
                if (lat_q == LAT_END) begin
                    out_buf_d  = cipher_text;
                    word_cnt_d = 2'd0;
                    lat_d      = 8'd0;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            DRAIN: begin
                if (hs_s) begin
                    out_buf_d  = {out_buf_q[95:0], 32'h0};
                    word_cnt_d = word_cnt_q + 2'd1;
                end else begin
                    out_buf_d = out_buf_q;
                end
            end
            default: lat_d = lat_q;
        endcase
    end

    // FSM output decode from the next state so the outputs come out of flops
    // aligned with the state they belong to.
    always_comb begin
        s_ready_d = (state_d == LOAD);
        start_d   = (state_d == START);
        m_valid_d = (state_d == DRAIN);
        m_last_d  = (state_d == DRAIN) && is_last_word(word_cnt_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_q      <= 8'd0;
            out_buf_q  <= 128'h0;
            word_cnt_q <= 2'd0;
            s_ready_q  <= 1'b0;
            start_q    <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            restart_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            lat_q      <= lat_d;
            out_buf_q  <= out_buf_d;
            word_cnt_q <= word_cnt_d;
            s_ready_q  <= s_ready_d;
            start_q    <= start_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            restart_q  <= key_done_s;
            err_drop_q <= err_drop_q | drop_s;
        end
    end

    assign s_ready  = s_ready_q;
    assign start    = start_q;
    assign restart  = restart_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign m_data   = out_buf_q[127:96];
    assign err_drop = err_drop_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Self-checking bench for aes_stream_loader. A behavioural AES-128 core
// model answers the start pulse after exactly LAT cycles; a word-level
// reference model predicts which blocks get encrypted and with what key.
module tb_aes_stream_loader;

    localparam int LAT = 40;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid, s_ready, s_key;
    logic [31:0]  s_data;
    logic         m_valid, m_ready, m_last;
    logic [31:0]  m_data;
    logic         err_drop, restart, start;
    logic [127:0] key_in, plain_text, cipher_text;

    aes_stream_loader #(.CORE_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_key       (s_key),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .err_drop    (err_drop),
        .key_in      (key_in),
        .plain_text  (plain_text),
        .restart     (restart),
        .start       (start),
        .cipher_text (cipher_text)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [0:43];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- core model: cipher valid only at cycle LAT ----------------
    logic [127:0] core_res = 128'h0;
    int           core_age = 0;
    logic         core_busy = 1'b0;

    // Behavioural core: latch the launch operands, age once per cycle.
    always @(negedge clk) begin
        if (start) begin
            core_res  <= aes_enc(key_in, plain_text);
            core_age  <= 0;
            core_busy <= 1'b1;
        end else if (core_busy) begin
            core_age <= core_age + 1;
        end
    end
    assign cipher_text = (core_busy && core_age == LAT) ? core_res : ~core_res;

    // ---------------- launch monitor ----------------
    int cyc = 0, start_cnt = 0, restart_cnt = 0, both_cnt = 0, start_cyc = 0, restart_cyc = 0;

    // Count start/restart pulses and remember when they last occurred.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start)   begin start_cnt   <= start_cnt + 1;   start_cyc   <= cyc; end
        if (restart) begin restart_cnt <= restart_cnt + 1; restart_cyc <= cyc; end
        if (start && restart) both_cnt <= both_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [127:0] m_key, m_pt;
    int           mk_cnt, mp_cnt, exp_start = 0, exp_restart = 0;
    logic         mk_loaded, mp_full, m_err;
    logic [31:0]  exp_q [$];

    task automatic model_reset();
        m_key = 128'h0; m_pt = 128'h0; mk_cnt = 0; mp_cnt = 0;
        mk_loaded = 1'b0; mp_full = 1'b0; m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] w, input logic k);
        logic [127:0] ct;
        if (k) begin
            if (mk_cnt == 0) mk_loaded = 1'b0;
            m_key = {m_key[95:0], w};
            if (mk_cnt == 3) begin mk_cnt = 0; mk_loaded = 1'b1; exp_restart++; end
            else mk_cnt++;
        end else if (mp_full) begin
            m_err = 1'b1;
        end else begin
            m_pt = {m_pt[95:0], w};
            mp_cnt++;
            if (mp_cnt == 4) mp_full = 1'b1;
        end
        if (mp_full && mk_loaded) begin
            ct = aes_enc(m_key, m_pt);
            for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
            exp_start++;
            mp_full = 1'b0;
            mp_cnt  = 0;
        end
    endtask

    // ---------------- output collector ----------------
    int           mode = 0;     // 0 always ready, 1 random, 2 hold off
    int           word_idx = 0;
    logic [127:0] last_blk = 128'h0;

    initial begin
        logic [31:0] e;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                m_ready  = 1'b0;
                word_idx = 0;
            end else begin
                case (mode)
                    0:       m_ready = 1'b1;
                    1:       m_ready = ($urandom_range(0, 3) != 0);
                    default: m_ready = 1'b0;
                endcase
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", m_data, 128'h0 - 128'h1);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e);
                        check("m_last", m_last, (word_idx == 3));
                        last_blk = {last_blk[95:0], m_data};
                        word_idx = (word_idx + 1) % 4;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [31:0] w, input logic k);
        int n;
        s_data = w; s_key = k; s_valid = 1'b1; n = 0;
        while (!s_ready && n < 300) begin @(negedge clk); n++; end
        if (!s_ready) begin
            check("send_timeout", 1'b0, 1'b1);
            s_valid = 1'b0;
        end else begin
            @(negedge clk);
            s_valid = 1'b0;
            model_accept(w, k);
        end
    endtask

    task automatic send_block(input logic [127:0] b, input logic k);
        for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], k);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && n < 600) begin @(negedge clk); n++; end
        check("drain_timeout", (exp_q.size() == 0 && !m_valid), 1'b1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- main sequence ----------------
    initial begin
        int sc, n, kleft, pleft, kw, pw, split;
        logic [127:0] rk, rp;
        reset_n = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_key = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_restart", restart, 1'b0);
        check("rst_err_drop", err_drop, 1'b0);
        check("rst_key_in", key_in, 128'h0);
        check("rst_plain_text", plain_text, 128'h0);
        check("rst_m_data", m_data, 128'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("ready_after_rst", s_ready, 1'b1);

        // FIPS-197 vector, key first
        send_block(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b0);
        wait_drain();
        check("t1_cipher", last_blk, FIPS_CT);
        check("t1_key_in", key_in, FIPS_KEY);
        check("t1_restarts", restart_cnt, exp_restart);

        // Back-to-back block reusing the key
        rp = {$urandom, $urandom, $urandom, $urandom};
        send_block(rp, 1'b0);
        wait_drain();
        check("t5_no_restart", restart_cnt, exp_restart);
        check("t5_starts", start_cnt, exp_start);

        // Backpressure on the first cipher word
        mode = 2;
        send_block(FIPS_PT, 1'b0);
        n = 0;
        while (!m_valid && n < LAT + 20) begin @(negedge clk); n++; end
        check("t3_reach_drain", m_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", m_valid, 1'b1);
            check("t3_hold_data", m_data, 32'h69c4e0d8);
        end
        mode = 0;
        wait_drain();
        check("t3_cipher", last_blk, FIPS_CT);

        // Plaintext first, key after
        do_reset();
        send_block(FIPS_PT, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        sc = start_cnt;
        check("t2_no_early_start", sc, exp_start);
        send_block(FIPS_KEY, 1'b1);
        wait_drain();
        check("t2_cipher", last_blk, FIPS_CT);
        check("t2_start_after_restart", (start_cyc > restart_cyc), 1'b1);
        check("t2_starts", start_cnt, sc + 1);

        // Overflow without a key
        do_reset();
        #1;
        sc = start_cnt;
        send_block(FIPS_PT, 1'b0);
        send_word($urandom, 1'b0);
        repeat (LAT + 10) @(negedge clk);
        #1;
        check("t4_err_drop", err_drop, 1'b1);
        check("t4_model_err", err_drop, m_err);
        check("t4_plain_text", plain_text, FIPS_PT);
        check("t4_no_start", start_cnt, sc);
        do_reset();
        check("t4_err_cleared", err_drop, 1'b0);

        // Randomized blocks, random interleave and backpressure
        mode = 1;
        for (int it = 0; it < 8; it++) begin
            rp = {$urandom, $urandom, $urandom, $urandom};
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                rk = {$urandom, $urandom, $urandom, $urandom};
                split = $urandom_range(0, 3);
                pw = 0; kw = 0;
                for (int i = 0; i < split; i++) begin send_word(rp[127-32*pw -: 32], 1'b0); pw++; end
                send_word(rk[127 -: 32], 1'b1); kw = 1;
                while (kw < 4 || pw < 4) begin
                    kleft = 4 - kw; pleft = 4 - pw;
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    if (pleft == 0 || (kleft != 0 && $urandom_range(0, 1) == 1)) begin
                        send_word(rk[127-32*kw -: 32], 1'b1); kw++;
                    end else begin
                        send_word(rp[127-32*pw -: 32], 1'b0); pw++;
                    end
                end
            end else begin
                send_block(rp, 1'b0);
            end
            wait_drain();
            check("rnd_key_in", key_in, m_key);
        end
        mode = 0;

        // Reset during WAIT
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        n = 0;
        while (!start && n < 50) begin @(negedge clk); n++; end
        check("t6_started", start, 1'b1);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_m_valid", m_valid, 1'b0);
        check("t6_rst_s_ready", s_ready, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_s_ready", s_ready, 1'b1);
        check("t6_m_valid", m_valid, 1'b0);
        #1;
        sc = start_cnt;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (LAT + 20) @(negedge clk);
        #1;
        check("t6_no_start", start_cnt, sc);
        check("t6_idle_m_valid", m_valid, 1'b0);

        check("total_starts", start_cnt, exp_start);
        check("total_restarts", restart_cnt, exp_restart);
        check("start_restart_overlap", both_cnt, 0);
        check("final_err_drop", err_drop, m_err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
